// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures an incoming asynchronous PWM waveform. The input is
//               synchronised, glitch-filtered and edge-detected, then a small
//               state machine times the period (rise to rise) and the high
//               time (rise to fall) in clk cycles. Loss of edges for TIMEOUT
//               cycles flags no_signal.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
  parameter int N       = 32,
  parameter int FILT    = 3,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         pwm_in,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         meas_valid,
  output logic         no_signal,
  output logic         level
);

  // Filter counter only needs to reach FILT-1; the toggle happens on the
  // FILT-th consecutive disagreeing cycle.
  localparam int             FW          = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [FW-1:0]  FILT_LAST   = FW'(FILT - 1);
  localparam logic [N-1:0]   TIMEOUT_CNT = N'(TIMEOUT);
  localparam logic [N-1:0]   CNT_ONE     = N'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  logic [1:0]    sync_q;
  logic          sync_s;
  logic [FW-1:0] fcnt_q;
  logic [FW-1:0] fcnt_d;
  logic          level_q;
  logic          level_d;
  logic          level_dly_q;
  logic          rise;
  logic          fall;
  logic          timeout;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [N-1:0]  cnt_q;
  logic [N-1:0]  cnt_d;
  logic [N-1:0]  hi_tmp_q;
  logic [N-1:0]  hi_tmp_d;
  logic [N-1:0]  period_q;
  logic [N-1:0]  period_d;
  logic [N-1:0]  high_q;
  logic [N-1:0]  high_d;
  logic          meas_valid_q;
  logic          meas_valid_d;
  logic          no_signal_q;
  logic          no_signal_d;

  // Two-flop synchroniser for the asynchronous PWM input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

  assign sync_s = sync_q[1];

  // Glitch filter: level follows the synchronised input only after FILT
  // consecutive disagreeing cycles; any agreeing cycle clears the count.
  always_comb begin
    fcnt_d  = '0;
    level_d = level_q;
    if (sync_s != level_q) begin
      if (fcnt_q == FILT_LAST) begin
        level_d = ~level_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Filter state and one-cycle delayed level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      fcnt_q      <= fcnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign rise    = level_q & ~level_dly_q;
  assign fall    = ~level_q & level_dly_q;
  assign timeout = (cnt_q == TIMEOUT_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a low enable overrides every other condition, and an
  // edge always takes precedence over a coincident timeout.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          if (rise) begin
            state_d = S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) begin
            state_d = S_LOW;
          end else if (rise) begin
            state_d = S_HIGH;
          end else if (timeout) begin
            state_d = S_ARM;
          end
        end
        S_LOW: begin
          if (rise) begin
            state_d = S_HIGH;
          end else if (timeout) begin
            state_d = S_ARM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath/output decode: counter restart, high-time capture and result
  // publication for the current state and detected edges.
  always_comb begin
    cnt_d        = cnt_q + CNT_ONE;
    hi_tmp_d     = hi_tmp_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    no_signal_d  = no_signal_q;
    if (!en) begin
      cnt_d       = '0;
      no_signal_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d       = '0;
          no_signal_d = 1'b1;
        end
        S_ARM: begin
          if (rise) begin
            cnt_d = CNT_ONE;
          end else if (timeout) begin
            cnt_d       = CNT_ONE;
            no_signal_d = 1'b1;
          end
        end
        S_HIGH: begin
          if (fall) begin
            hi_tmp_d = cnt_q;
          end else if (rise) begin
            cnt_d = CNT_ONE;
          end else if (timeout) begin
            cnt_d       = CNT_ONE;
            no_signal_d = 1'b1;
          end
        end
        S_LOW: begin
          if (rise) begin
            cnt_d        = CNT_ONE;
            period_d     = cnt_q;
            high_d       = hi_tmp_q;
            meas_valid_d = 1'b1;
            no_signal_d  = 1'b0;
          end else if (timeout) begin
            cnt_d       = CNT_ONE;
            no_signal_d = 1'b1;
          end
        end
        default: begin
          cnt_d       = '0;
          no_signal_d = 1'b1;
        end
      endcase
    end
  end

  // Measurement registers; no_signal resets high because nothing is measured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      hi_tmp_q     <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      no_signal_q  <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      hi_tmp_q     <= hi_tmp_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = meas_valid_q;
  assign no_signal  = no_signal_q;
  assign level      = level_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture. Drives PWM periods from
//               a list of (period, high) pairs, predicts each measurement
//               from the waveform it drives, and checks them as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

  localparam int N       = 32;
  localparam int FILT    = 3;
  localparam int TIMEOUT = 5000;
  // Input edge to registered result: synchroniser, filter, edge detect, latch.
  localparam int LAT     = 3 + FILT;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         pwm_in = 1'b0;
  logic [N-1:0] period;
  logic [N-1:0] high_time;
  logic         meas_valid;
  logic         no_signal;
  logic         level;

  pwm_capture #(.N(N), .FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .no_signal  (no_signal),
    .level      (level)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Expected measurements: the period that just ended, due LAT cycles after
  // the rising input edge that closes it.
  typedef struct {
    int     p;
    int     h;
    longint at;
  } exp_t;

  exp_t exp_q[$];
  int   prev_p = 0;
  int   prev_h = 0;
  bit   have_prev = 1'b0;
  int   last_p = 0;
  int   last_h = 0;

  task automatic note_rise(input int p, input int h);
    if (have_prev) begin
      exp_q.push_back('{prev_p, prev_h, cyc + LAT});
      last_p = prev_p;
      last_h = prev_h;
    end
    prev_p    = p;
    prev_h    = h;
    have_prev = 1'b1;
  endtask

  // Scoreboard: every meas_valid must match the oldest prediction exactly.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_meas_valid", meas_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("meas_cycle", cyc, mon_e.at);
          check_val("period", period, mon_e.p);
          check_val("high_time", high_time, mon_e.h);
          check_val("no_signal_at_meas", no_signal, 0);
        end
      end else if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
        check_val("missed_meas_valid", meas_valid, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // One PWM period: high for h, low for p-h. Optional glitches of width gw in
  // the middle of each phase, optional enable drop, optional async reset.
  task automatic run_period(input int p, input int h, input int gw,
                            input int en_off_at, input int en_on_at, input int rst_at);
    logic v;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (i == 0) note_rise(p, h);
      v = (i < h);
      if (gw > 0) begin
        if ((i >= h / 2 && i < h / 2 + gw) ||
            (i >= h + (p - h) / 2 && i < h + (p - h) / 2 + gw)) begin
          v = ~v;
        end
      end
      pwm_in = v;
      if (i == h - 1) check_val("level_high_phase", level, 1);
      if (i == p - 1) check_val("level_low_phase", level, 0);
      if (i == en_off_at) begin
        en        = 1'b0;
        have_prev = 1'b0;
      end
      if (en_on_at > 0 && i == en_on_at - 1) begin
        check_val("disabled_no_signal", no_signal, 1);
        check_val("disabled_period_held", period, last_p);
        check_val("disabled_high_held", high_time, last_h);
      end
      if (i == en_on_at) en = 1'b1;
      if (i == rst_at) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_period", period, 0);
        check_val("rst_high_time", high_time, 0);
        check_val("rst_meas_valid", meas_valid, 0);
        check_val("rst_no_signal", no_signal, 1);
        check_val("rst_level", level, 0);
        have_prev = 1'b0;
      end
      if (rst_at >= 0 && i == rst_at + 4) rst_n = 1'b1;
    end
  endtask

  // Rise then hold high for x cycles (long enough to time out), then low.
  task automatic hold_high(input int x, input int l);
    longint c0;
    c0 = 0;
    for (int i = 0; i < x + l; i++) begin
      @(negedge clk);
      if (i == 0) begin
        note_rise(0, 0);
        have_prev = 1'b0;
        c0 = cyc;
      end
      pwm_in = (i < x);
      if (cyc == c0 + LAT - 1 + TIMEOUT) check_val("no_signal_before_timeout", no_signal, 0);
      if (cyc == c0 + LAT + TIMEOUT) begin
        check_val("no_signal_at_timeout", no_signal, 1);
        check_val("level_static_high", level, 1);
        check_val("timeout_period_held", period, last_p);
        check_val("timeout_high_held", high_time, last_h);
      end
      if (i == x + l - 1) check_val("no_signal_after_loss", no_signal, 1);
    end
  endtask

  initial begin
    int p;
    int h;
    repeat (3) @(negedge clk);
    check_val("reset_period", period, 0);
    check_val("reset_high_time", high_time, 0);
    check_val("reset_meas_valid", meas_valid, 0);
    check_val("reset_no_signal", no_signal, 1);
    check_val("reset_level", level, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_no_signal", no_signal, 1);
    en = 1'b1;
    repeat (3) @(negedge clk);

    // Steady 1000/250 stream.
    for (int k = 0; k < 6; k++) run_period(1000, 250, 0, -1, -1, -1);
    check_val("steady_no_signal", no_signal, 0);
    // Same stream with sub-filter glitches in both phases.
    for (int k = 0; k < 4; k++) run_period(1000, 250, 2, -1, -1, -1);
    // Signal loss with input stuck high, then resume at 1000/400.
    hold_high(TIMEOUT + 100, 200);
    for (int k = 0; k < 4; k++) run_period(1000, 400, 0, -1, -1, -1);
    check_val("resumed_no_signal", no_signal, 0);
    // Duty change at a period boundary.
    for (int k = 0; k < 3; k++) run_period(1000, 250, 0, -1, -1, -1);
    for (int k = 0; k < 3; k++) run_period(1000, 750, 0, -1, -1, -1);
    // Enable dropped mid-high for 300 cycles.
    run_period(1000, 250, 0, 100, 400, -1);
    for (int k = 0; k < 3; k++) run_period(1000, 250, 0, -1, -1, -1);
    // Asynchronous reset in the low phase, then the first scenario again.
    run_period(1000, 250, 0, -1, -1, 600);
    for (int k = 0; k < 4; k++) run_period(1000, 250, 0, -1, -1, -1);
    // Randomised periods, duties and glitch widths below the filter length.
    for (int k = 0; k < 25; k++) begin
      p = int'($urandom_range(400, 40));
      h = int'($urandom_range(p - 16, 16));
      run_period(p, h, int'($urandom_range(FILT - 1, 0)), -1, -1, -1);
    end
    // Close the last random period and let its result land.
    run_period(100, 50, 0, -1, -1, -1);
    repeat (LAT + 10) @(negedge clk);
    check_val("pending_meas", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
